bram_port_arbiter: RTL

//   Shares one port of the dual-port BRAM between two requesters. Typical

---
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with a
// bounded burst lock and in-order read-data routing back to the issuer.
module bram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_valid,
  output logic [1:0]              o_req_ready,
  input  logic [1:0]              i_req_we,
  input  logic [1:0]              i_req_lock,
  input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
  output logic [1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic                    o_bram_en,
  output logic                    o_bram_we,
  output logic [ADDR_WIDTH-1:0]   o_bram_addr,
  output logic [DATA_WIDTH-1:0]   o_bram_wdata,
  input  logic [DATA_WIDTH-1:0]   i_bram_rdata
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  logic                  last_grant_q, last_grant_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic                  gnt;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  bram_id_q;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_id_q;

  // Any valid requester is always granted, so accept is just "someone valid".
  always_comb begin
    gnt = 1'b0;
    unique case (i_req_valid)
      2'b00: gnt = 1'b0;
      2'b01: gnt = 1'b0;
      2'b10: gnt = 1'b1;
      2'b11: begin
        if (i_req_lock[last_grant_q] && (hold_cnt_q < HoldMax)) gnt = last_grant_q;
        else                                                     gnt = ~last_grant_q;
      end
    endcase
    accept      = |i_req_valid;
    o_req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    sel_we      = i_req_we[gnt];
    sel_addr    = gnt ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH] : i_req_addr[0 +: ADDR_WIDTH];
    sel_wdata   = gnt ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH] : i_req_wdata[0 +: DATA_WIDTH];
  end

  always_comb begin
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    if (accept) begin
      last_grant_d = gnt;
      if (gnt != last_grant_q)       hold_cnt_d = HoldW'(1);
      else if (hold_cnt_q < HoldMax) hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant_q <= 1'b1;
      hold_cnt_q   <= '0;
      o_bram_en    <= 1'b0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_wdata <= '0;
      bram_id_q    <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      o_bram_en    <= accept;
      if (accept) begin
        o_bram_we    <= sel_we;
        o_bram_addr  <= sel_addr;
        o_bram_wdata <= sel_wdata;
        bram_id_q    <= gnt;
      end
      // Tag shift register tracks which requester owns each read in flight.
      for (int i = int'(RD_LATENCY) - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      tag_vld_q[0] <= o_bram_en & ~o_bram_we;
      tag_id_q[0]  <= bram_id_q;
    end
  end

  assign o_rsp_valid = tag_vld_q[RD_LATENCY-1] ?
                       (tag_id_q[RD_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data  = i_bram_rdata;

endmodule
